// File: rtl/scr1_mprf_pkg.sv
// Shared constants and types for the multi-port register file and its scoreboard.
package scr1_mprf_pkg;
   localparam int MPRF_XLEN   = 32;
   localparam int MPRF_AW     = 5;
   localparam int NREGS_RV32I = 32;
   localparam int NREGS_RV32E = 16;

   typedef logic [MPRF_AW-1:0]   mprf_addr_t;
   typedef logic [MPRF_XLEN-1:0] mprf_data_t;

   // x0 and anything beyond the implemented file is a hole: reads 0, never written or busy.
   function automatic logic addr_ok(input mprf_addr_t a, input int nregs);
      return (a != '0) && (int'(a) < nregs);
   endfunction
endpackage

// File: rtl/scr1_pipe_mprf_mp_if.sv
// Read/write/alloc bundle of the multi-port register file.
interface scr1_pipe_mprf_mp_if
   import scr1_mprf_pkg::*;
#(
   parameter int XLEN = MPRF_XLEN,
   parameter int NRD  = 2,
   parameter int AW   = MPRF_AW
);
   logic [NRD*AW-1:0]   rd_addr_i;
   logic [NRD*XLEN-1:0] rd_data_o;
   logic [NRD-1:0]      rd_busy_o;
   logic                alloc_req_i;
   logic [AW-1:0]       alloc_addr_i;
   logic                w0_req_i;
   logic [AW-1:0]       w0_addr_i;
   logic [XLEN-1:0]     w0_data_i;
   logic                w1_req_i;
   logic [AW-1:0]       w1_addr_i;
   logic [XLEN-1:0]     w1_data_i;
   logic [AW:0]         pend_cnt_o;
   logic                err_o;

   modport master (
      output rd_addr_i, alloc_req_i, alloc_addr_i,
             w0_req_i, w0_addr_i, w0_data_i, w1_req_i, w1_addr_i, w1_data_i,
      input  rd_data_o, rd_busy_o, pend_cnt_o, err_o
   );
   modport slave (
      input  rd_addr_i, alloc_req_i, alloc_addr_i,
             w0_req_i, w0_addr_i, w0_data_i, w1_req_i, w1_addr_i, w1_data_i,
      output rd_data_o, rd_busy_o, pend_cnt_o, err_o
   );
endinterface

// File: rtl/scr1_mprf_sb.sv
// Pending-write scoreboard: busy bits, registered busy count and sticky protocol error.
module scr1_mprf_sb
   import scr1_mprf_pkg::*;
#(
   parameter int NREGS = NREGS_RV32I,
   parameter int AW    = MPRF_AW
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             alloc_req,
   input  logic [AW-1:0]    alloc_addr,
   input  logic             w0_req,
   input  logic [AW-1:0]    w0_addr,
   input  logic             w1_req,
   input  logic [AW-1:0]    w1_addr,
   output logic [NREGS-1:0] busy,
   output logic [AW:0]      pend_cnt,
   output logic             err
);
   localparam int CW = AW + 1;

   logic [NREGS-1:0] busy_nxt;
   logic [AW:0]      cnt_nxt;
   logic             err_evt;

   // Only implemented registers are scanned, so holes are ignored without error.
   // A w1 clearing the same register in the same cycle legitimises a new alloc or an EXU write.
   always_comb begin
      busy_nxt = '0;
      cnt_nxt  = '0;
      err_evt  = 1'b0;
      for (int r = 1; r < NREGS; r++) begin
         logic al, c1, z0;
         al = alloc_req && (alloc_addr == AW'(r));
         c1 = w1_req    && (w1_addr    == AW'(r));
         z0 = w0_req    && (w0_addr    == AW'(r));
         busy_nxt[r] = al | (busy[r] & ~c1);
         if (c1 && !busy[r])         err_evt = 1'b1;
         if (al && busy[r] && !c1)   err_evt = 1'b1;
         if (z0 && busy[r] && !c1)   err_evt = 1'b1;
         cnt_nxt = cnt_nxt + CW'(busy_nxt[r]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= '0;
         pend_cnt <= '0;
         err      <= 1'b0;
      end else begin
         busy     <= busy_nxt;
         pend_cnt <= cnt_nxt;
         err      <= err | err_evt;
      end
   end
endmodule

// File: rtl/scr1_pipe_mprf_mp.sv
// Multi-port register file with late-write port and pending-write scoreboard.
// Same-cycle write-to-read forwarding is enabled by defining SCR1_MPRF_BYPASS_EN.
module scr1_pipe_mprf_mp
   import scr1_mprf_pkg::*;
#(
   parameter int XLEN  = MPRF_XLEN,
   parameter int NREGS = NREGS_RV32I,
   parameter int NRD   = 2,
   parameter int AW    = MPRF_AW
)(
   input  logic              clk,
   input  logic              rst_n,
   scr1_pipe_mprf_mp_if.slave mprf
);
   logic [XLEN-1:0]  regs [1:NREGS-1];
   logic [NREGS-1:0] busy;

   scr1_mprf_sb #(.NREGS(NREGS), .AW(AW)) u_sb (
      .clk        (clk),
      .rst_n      (rst_n),
      .alloc_req  (mprf.alloc_req_i),
      .alloc_addr (mprf.alloc_addr_i),
      .w0_req     (mprf.w0_req_i),
      .w0_addr    (mprf.w0_addr_i),
      .w1_req     (mprf.w1_req_i),
      .w1_addr    (mprf.w1_addr_i),
      .busy       (busy),
      .pend_cnt   (mprf.pend_cnt_o),
      .err        (mprf.err_o)
   );

   // w0 wins a same-register collision: it belongs to the younger instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 1; r < NREGS; r++) regs[r] <= '0;
      end else begin
         for (int r = 1; r < NREGS; r++) begin
            if (mprf.w0_req_i && (mprf.w0_addr_i == AW'(r)))
               regs[r] <= mprf.w0_data_i;
            else if (mprf.w1_req_i && (mprf.w1_addr_i == AW'(r)))
               regs[r] <= mprf.w1_data_i;
         end
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rdata;
      logic            rbusy;

      assign ra = mprf.rd_addr_i[k*AW +: AW];

      always_comb begin
         rdata = '0;
         rbusy = 1'b0;
         for (int r = 1; r < NREGS; r++) begin
            if (ra == AW'(r)) begin
               rdata = regs[r];
               rbusy = busy[r];
            end
         end
`ifdef SCR1_MPRF_BYPASS_EN
         // Forwarding only for implemented registers; a same-cycle alloc keeps the new owner busy.
         if (addr_ok(ra, NREGS)) begin
            if (mprf.w1_req_i && (mprf.w1_addr_i == ra)) begin
               rdata = mprf.w1_data_i;
               if (!(mprf.alloc_req_i && (mprf.alloc_addr_i == ra))) rbusy = 1'b0;
            end
            if (mprf.w0_req_i && (mprf.w0_addr_i == ra)) rdata = mprf.w0_data_i;
         end
`endif
      end

      assign mprf.rd_data_o[k*XLEN +: XLEN] = rdata;
      assign mprf.rd_busy_o[k]              = rbusy;
   end
endmodule

// File: doc/scr1_pipe_mprf_mp.md
# scr1_pipe_mprf_mp

Parametrised multi-port integer register file with a pending-write scoreboard. It is the successor to the single-write, two-read MPRF, sitting between the EXU issue stage and the two write-back paths: single-cycle EXU results and late LSU/MUL-DIV results. It supports a configurable register count (RV32I/RV32E), any number of read ports, a second late-write port, and per-register busy tracking. The busy bits let issue logic stall on RAW/WAW hazards.

## Interface
Parameters:
- XLEN, 32, data width.
- NREGS, 32, architectural register count (32 = RV32I, 16 = RV32E). x0 is always included.
- NRD, 2, number of read ports (1..4).
- AW, 5, address width. Fixed at 5 regardless of NREGS.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr_i  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
- rd_data_o  out  NRD*XLEN  read data per port.
- rd_busy_o  out  NRD  register addressed by port k has a pending late write.
- alloc_req_i  in  1  long-latency op issued; mark destination busy.
- alloc_addr_i  in  AW  destination of the allocating op.
- w0_req_i  in  1  EXU write-back request.
- w0_addr_i  in  AW  EXU destination.
- w0_data_i  in  XLEN  EXU result.
- w1_req_i  in  1  late (LSU/MDU) write-back request; clears busy.
- w1_addr_i  in  AW  late destination.
- w1_data_i  in  XLEN  late result.
- pend_cnt_o  out  AW+1  number of registers currently busy.
- err_o  out  1  sticky protocol error.

## Operation
- Valid address: 1..NREGS-1. Address 0 or any address ≥ NREGS reads 0 and is never busy. Writes and allocs to such addresses are ignored without error.
- Storage: NREGS-1 words of XLEN bits; reset value 0. busy[] resets to 0, pend_cnt_o to 0, err_o to 0.
- Write priority, when w0 and w1 target the same valid address in one cycle: the register takes w0_data_i (w0 is the younger op). busy is still cleared by w1.
- Scoreboard update per valid address a, each cycle:
  - busy_next = alloc(a) | (busy(a) & ~w1(a)).
  - Alloc and w1-clear on the same address: busy stays 1 (new op owns it).
- pend_cnt_o = population count of busy[]. It is registered and updated together with busy, so it never exceeds NREGS-1.
- err_o sets, and holds until reset, on any of:
  - w1 to a valid address whose busy is 0;
  - alloc to a valid address already busy and not cleared by w1 in the same cycle (WAW issue violation);
  - w0 to a valid busy address.
  
  In all three cases the write itself still takes effect.

## Timing
- Reads are combinational from registered state. Writes and scoreboard updates take effect at the next rising clk.
- Latency is 0 cycles with bypass and 1 cycle without (see Configuration).
- rd_busy_o is combinational from busy[], with the bypass rules below.
- Reset mid-operation clears all registers and busy bits asynchronously. Late writes still in flight after reset are the issuer's responsibility. A w1 arriving after reset sets err_o.

## Configuration
- SCR1_MPRF_BYPASS_EN defined:
  - A read whose address matches a same-cycle valid write returns the write data (w0 over w1).
  - rd_busy_o is deasserted in the same cycle as a matching w1, unless a same-cycle alloc targets that address.
  - Read-after-write latency is 0.
- SCR1_MPRF_BYPASS_EN undefined:
  - Reads and rd_busy_o reflect registered state only.
  - Read-after-write latency is 1 cycle.

## Structure
- Package scr1_mprf_pkg holds: XLEN default, AW, NREGS_RV32I=32, NREGS_RV32E=16, and the typedefs for register address and register data.
- Sub-module scr1_mprf_sb: busy vector, alloc/clear logic, pend_cnt_o popcount register, and err_o. Register array, write muxing and read/bypass muxes stay in the top module.

## Test plan
- Reset, then read all addresses on every port -> all 0; rd_busy_o=0, pend_cnt_o=0, err_o=0.
- w0 writes x5=0xDEADBEEF, same cycle read x5 -> 0xDEADBEEF with bypass, 0 without; next cycle -> 0xDEADBEEF in both configurations.
- alloc x7; two cycles later w1 x7=0x12345678 -> rd_busy_o high in between, pend_cnt_o 1→0; x7 reads 0x12345678 afterwards; err_o=0.
- w0 x3=0x1 and w1 x3=0x2 in the same cycle, x3 busy -> x3=0x1, busy cleared, err_o stays 0.
- alloc x9 while w1 clears x9 -> busy stays 1, pend_cnt_o unchanged.
- NREGS=16: write x20=0x55 and w1 to idle x4 -> x20 reads 0, err_o=1 on the w1 only.
